ocx_tlx_afu_data_rd_seq: RTL and testbench

AFU-side read sequencer sitting directly downstream of the TLX receive data FIFOs, one instance per data VC (command or response). Accepts a read job from the AFU engine, issues a single `afu_tlx_rd_req` pulse with the encoded flit count, and captures the returned 512-bit flits and their BDI into an internal skid buffer. It then presents them as a ready/valid stream tagged with the job's tag, so the AFU can back-pressure even though the TLX data path cannot be stalled.

---
 rtl/ocx_tlx_afu_pkg.sv | 25 ++
 rtl/ocx_tlx_afu_skid_buf.sv | 72 +++++++
 rtl/ocx_tlx_afu_data_rd_seq.sv | 159 +++++++++++++++
 tb/tb_ocx_tlx_afu_data_rd_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocx_tlx_afu_pkg.sv
// Shared definitions for the AFU-side TLX data read sequencer.
package ocx_tlx_afu_pkg;

  // Sequencer states: wait for a job, wait for buffer room, collect the flits.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } rd_state_e;

  // Largest flit count a single read request can carry.
  localparam int unsigned MAX_RD_FLITS = 8;

  // Encode a legal flit count (1..8) into the 3-bit request field; 8 wraps to 0.
  function automatic logic [2:0] enc_rd_cnt(input logic [3:0] flits);
    logic [2:0] cnt;
    if (flits == 4'd8) begin
      cnt = 3'b000;
    end else begin
      cnt = flits[2:0];
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ocx_tlx_afu_skid_buf.sv
// Circular skid buffer holding returned flits plus their per-beat metadata.
// The head entry is presented combinationally from registered storage.
module ocx_tlx_afu_skid_buf #(
  parameter int DEPTH     = 8,
  parameter int TAG_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [511:0]             i_data,
  input  logic                     i_bdi,
  input  logic                     i_last,
  input  logic                     i_bad,
  input  logic [TAG_WIDTH-1:0]     i_tag,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [511:0]             o_data,
  output logic                     o_bdi,
  output logic                     o_last,
  output logic                     o_bad,
  output logic [TAG_WIDTH-1:0]     o_tag,
  output logic [$clog2(DEPTH):0]   o_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   OCC_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_occ;
  logic [511:0]         r_data [DEPTH];
  logic [TAG_WIDTH+2:0] r_meta [DEPTH];

  // Storage write; entries carry no reset since they are only read when occupied.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_data[r_wr_ptr] <= i_data;
      r_meta[r_wr_ptr] <= {i_bdi, i_last, i_bad, i_tag};
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keeps occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;
  assign o_data  = r_data[r_rd_ptr];
  assign o_bdi   = r_meta[r_rd_ptr][TAG_WIDTH+2];
  assign o_last  = r_meta[r_rd_ptr][TAG_WIDTH+1];
  assign o_bad   = r_meta[r_rd_ptr][TAG_WIDTH];
  assign o_tag   = r_meta[r_rd_ptr][TAG_WIDTH-1:0];

endmodule

// File: rtl/ocx_tlx_afu_data_rd_seq.sv
// AFU-side read sequencer: issues one TLX read per job, captures the returned
// flits into a skid buffer and replays them as a back-pressurable stream.
module ocx_tlx_afu_data_rd_seq
  import ocx_tlx_afu_pkg::*;
#(
  parameter int BUF_DEPTH = 8,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 tlx_clk,
  input  logic                 reset_n,
  input  logic                 job_v,
  output logic                 job_rdy,
  input  logic [3:0]           job_flits,
  input  logic [TAG_WIDTH-1:0] job_tag,
  output logic                 job_err,
  output logic                 afu_tlx_rd_req,
  output logic [2:0]           afu_tlx_rd_cnt,
  input  logic                 tlx_afu_data_valid,
  input  logic [511:0]         tlx_afu_data_bus,
  input  logic                 tlx_afu_data_bdi,
  output logic                 out_v,
  input  logic                 out_rdy,
  output logic [511:0]         out_data,
  output logic                 out_bdi,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_last,
  output logic                 out_job_bad,
  output logic                 unexp_data_err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

  rd_state_e            r_state;
  logic                 r_job_rdy;
  logic                 r_job_err;
  logic                 r_rd_req;
  logic [2:0]           r_rd_cnt;
  logic [3:0]           r_flits;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [2:0]           r_beat_cnt;
  logic                 r_bad_acc;
  logic                 r_unexp;

  logic                 w_job_legal;
  logic                 w_room;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_last;
  logic                 w_bad;
  logic [AW:0]          w_occ;
  logic [AW:0]          w_free;
  logic                 w_head_v;
  logic                 w_head_bad;
  logic                 w_head_last;

  assign w_job_legal = (job_flits != 4'd0) && (job_flits <= 4'(MAX_RD_FLITS));
  assign w_free      = DEPTH_C - w_occ;
  // Only occupancy can change while in REQ (pops), so room never shrinks there.
  assign w_room      = (w_free >= (AW+1)'(r_flits));
  assign w_push      = (r_state == ST_WAIT) && tlx_afu_data_valid;
  assign w_pop       = w_head_v && out_rdy;
  assign w_last      = ({1'b0, r_beat_cnt} == (r_flits - 4'd1));
  assign w_bad       = r_bad_acc | tlx_afu_data_bdi;

  // Job sequencing FSM with registered handshake, request and error outputs.
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_job_rdy  <= 1'b1;
      r_job_err  <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_cnt   <= 3'd0;
      r_flits    <= 4'd0;
      r_tag      <= '0;
      r_beat_cnt <= 3'd0;
      r_bad_acc  <= 1'b0;
      r_unexp    <= 1'b0;
    end else begin
      r_job_err <= 1'b0;
      r_rd_req  <= 1'b0;
      r_rd_cnt  <= 3'd0;
      // Flits arriving outside a collection window have no owner: drop and flag.
      if (tlx_afu_data_valid && (r_state != ST_WAIT)) begin
        r_unexp <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (job_v && r_job_rdy) begin
            if (w_job_legal) begin
              r_flits   <= job_flits;
              r_tag     <= job_tag;
              r_job_rdy <= 1'b0;
              r_state   <= ST_REQ;
            end else begin
              r_job_err <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (w_room) begin
            r_rd_req   <= 1'b1;
            r_rd_cnt   <= enc_rd_cnt(r_flits);
            r_beat_cnt <= 3'd0;
            r_bad_acc  <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tlx_afu_data_valid) begin
            r_beat_cnt <= r_beat_cnt + 3'd1;
            r_bad_acc  <= w_bad;
            if (w_last) begin
              r_job_rdy <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: begin
          r_job_rdy <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  ocx_tlx_afu_skid_buf #(
    .DEPTH     (BUF_DEPTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_skid_buf (
    .i_clk   (tlx_clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (tlx_afu_data_bus),
    .i_bdi   (tlx_afu_data_bdi),
    .i_last  (w_last),
    .i_bad   (w_bad),
    .i_tag   (r_tag),
    .i_pop   (w_pop),
    .o_valid (w_head_v),
    .o_data  (out_data),
    .o_bdi   (out_bdi),
    .o_last  (w_head_last),
    .o_bad   (w_head_bad),
    .o_tag   (out_tag),
    .o_occ   (w_occ)
  );

  assign job_rdy        = r_job_rdy;
  assign job_err        = r_job_err;
  assign afu_tlx_rd_req = r_rd_req;
  assign afu_tlx_rd_cnt = r_rd_cnt;
  assign unexp_data_err = r_unexp;
  assign out_v          = w_head_v;
  assign out_last       = w_head_last;
  // The job-level bad flag is only meaningful on the closing beat.
  assign out_job_bad    = w_head_bad & w_head_last;

endmodule

// File: tb/tb_ocx_tlx_afu_data_rd_seq.sv
// Self-checking bench: a queue-based model of the job/stream behaviour is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_ocx_tlx_afu_data_rd_seq;

  localparam int BUF_DEPTH = 8;

  logic         tlx_clk = 1'b0;
  logic         reset_n;
  logic         job_v;
  logic         job_rdy;
  logic [3:0]   job_flits;
  logic [7:0]   job_tag;
  logic         job_err;
  logic         afu_tlx_rd_req;
  logic [2:0]   afu_tlx_rd_cnt;
  logic         tlx_afu_data_valid;
  logic [511:0] tlx_afu_data_bus;
  logic         tlx_afu_data_bdi;
  logic         out_v;
  logic         out_rdy;
  logic [511:0] out_data;
  logic         out_bdi;
  logic [7:0]   out_tag;
  logic         out_last;
  logic         out_job_bad;
  logic         unexp_data_err;

  ocx_tlx_afu_data_rd_seq #(.BUF_DEPTH(BUF_DEPTH), .TAG_WIDTH(8)) dut (
    .tlx_clk            (tlx_clk),
    .reset_n            (reset_n),
    .job_v              (job_v),
    .job_rdy            (job_rdy),
    .job_flits          (job_flits),
    .job_tag            (job_tag),
    .job_err            (job_err),
    .afu_tlx_rd_req     (afu_tlx_rd_req),
    .afu_tlx_rd_cnt     (afu_tlx_rd_cnt),
    .tlx_afu_data_valid (tlx_afu_data_valid),
    .tlx_afu_data_bus   (tlx_afu_data_bus),
    .tlx_afu_data_bdi   (tlx_afu_data_bdi),
    .out_v              (out_v),
    .out_rdy            (out_rdy),
    .out_data           (out_data),
    .out_bdi            (out_bdi),
    .out_tag            (out_tag),
    .out_last           (out_last),
    .out_job_bad        (out_job_bad),
    .unexp_data_err     (unexp_data_err)
  );

  always #5 tlx_clk = ~tlx_clk;

  typedef struct {
    logic [511:0] d;
    logic         bdi;
    logic [7:0]   tag;
    logic         last;
    logic         bad;
  } beat_t;

  // Model state
  beat_t      mq[$];
  logic       m_busy     = 1'b0;
  logic       m_pending  = 1'b0;
  logic       m_inflight = 1'b0;
  logic       m_unexp    = 1'b0;
  logic       m_err_exp  = 1'b0;
  logic       m_acc      = 1'b0;
  int         m_flits    = 0;
  int         m_cnt      = 0;
  logic [7:0] m_tag      = 8'h00;
  logic       req_seen   = 1'b0;

  // Observation counters for literal expectations
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_req  = 0;
  int         n_err  = 0;
  int         n_pop  = 0;
  int         n_last = 0;
  int         n_bdi  = 0;
  logic [2:0] last_cnt = 3'd7;
  logic       last_bad = 1'b0;
  logic [7:0] last_tag = 8'h00;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk(input logic [7:0] t, input int i);
    logic [511:0] d;
    d = {64{t}};
    d[15:0] = 16'(i) ^ 16'hA5C3;
    d[511:496] = 16'(i * 7 + 1);
    return d;
  endfunction

  // Behavioural model: advances on each clock edge, cleared by async reset.
  initial begin
    logic  was_busy;
    beat_t b;
    forever begin
      @(posedge tlx_clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_busy = 1'b0; m_pending = 1'b0; m_inflight = 1'b0;
        m_unexp = 1'b0; m_err_exp = 1'b0; m_acc = 1'b0; m_cnt = 0;
      end else begin
        was_busy  = m_busy;
        m_err_exp = 1'b0;
        if (out_rdy && mq.size() > 0) mq.delete(0);
        if (req_seen && m_pending) begin
          m_pending = 1'b0; m_inflight = 1'b1; m_cnt = 0; m_acc = 1'b0;
        end
        if (tlx_afu_data_valid) begin
          if (m_inflight) begin
            m_acc  = m_acc | tlx_afu_data_bdi;
            b.d    = tlx_afu_data_bus;
            b.bdi  = tlx_afu_data_bdi;
            b.tag  = m_tag;
            b.last = (m_cnt == m_flits - 1);
            b.bad  = m_acc;
            mq.push_back(b);
            m_cnt++;
            if (b.last) begin
              m_inflight = 1'b0;
              m_busy     = 1'b0;
            end
          end else begin
            m_unexp = 1'b1;
          end
        end
        if (job_v && !was_busy) begin
          if (job_flits >= 4'd1 && job_flits <= 4'd8) begin
            m_busy = 1'b1; m_pending = 1'b1;
            m_flits = int'(job_flits); m_tag = job_tag;
          end else begin
            m_err_exp = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: checks DUT outputs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge tlx_clk);
      if (!reset_n) begin
        req_seen = 1'b0;
      end else begin
        chk("job_rdy", 512'(job_rdy), 512'(!m_busy));
        chk("job_err", 512'(job_err), 512'(m_err_exp));
        chk("unexp", 512'(unexp_data_err), 512'(m_unexp));
        chk("out_v", 512'(out_v), 512'(mq.size() != 0));
        if (mq.size() != 0) begin
          chk("out_data", out_data, mq[0].d);
          chk("out_bdi", 512'(out_bdi), 512'(mq[0].bdi));
          chk("out_tag", 512'(out_tag), 512'(mq[0].tag));
          chk("out_last", 512'(out_last), 512'(mq[0].last));
          chk("out_job_bad", 512'(out_job_bad), 512'(mq[0].last ? mq[0].bad : 1'b0));
        end
        if (afu_tlx_rd_req) begin
          n_req++;
          last_cnt = afu_tlx_rd_cnt;
          chk("req_pending", 512'(m_pending), 512'(1'b1));
          chk("req_cnt", 512'(afu_tlx_rd_cnt), 512'((m_flits == 8) ? 0 : m_flits));
          chk("req_room", 512'((BUF_DEPTH - mq.size()) >= m_flits), 512'(1'b1));
        end
        if (job_err) n_err++;
        if (out_v && out_rdy) begin
          n_pop++;
          last_tag = out_tag;
          if (out_bdi) n_bdi++;
          if (out_last) begin
            n_last++;
            last_bad = out_job_bad;
          end
        end
        req_seen = afu_tlx_rd_req;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge tlx_clk);
      #1;
    end
  endtask

  task automatic job(input logic [3:0] f, input logic [7:0] t);
    job_v = 1'b1; job_flits = f; job_tag = t;
    cyc(1);
    job_v = 1'b0;
  endtask

  task automatic wait_req(input string nm, input int bound);
    int start;
    start = n_req;
    for (int i = 0; i < bound; i++) begin
      cyc(1);
      if (n_req != start) break;
    end
    chk(nm, 512'(n_req != start), 512'(1'b1));
  endtask

  task automatic beats(input int n, input logic [7:0] t, input int bdi_idx, input int gap);
    for (int i = 0; i < n; i++) begin
      tlx_afu_data_valid = 1'b1;
      tlx_afu_data_bus   = mk(t, i);
      tlx_afu_data_bdi   = (i == bdi_idx);
      cyc(1);
      tlx_afu_data_valid = 1'b0;
      tlx_afu_data_bdi   = 1'b0;
      cyc(gap);
    end
  endtask

  task automatic drain(input string nm, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (mq.size() == 0 && !m_busy) break;
      cyc(1);
    end
    chk(nm, 512'(mq.size()), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, l0, b0, e0, r0;
    reset_n = 1'b0; job_v = 1'b0; job_flits = 4'd0; job_tag = 8'h00;
    tlx_afu_data_valid = 1'b0; tlx_afu_data_bus = '0; tlx_afu_data_bdi = 1'b0;
    out_rdy = 1'b1;
    cyc(3);
    chk("rst_job_rdy", 512'(job_rdy), 512'(1'b1));
    chk("rst_job_err", 512'(job_err), 512'(1'b0));
    chk("rst_rd_req", 512'(afu_tlx_rd_req), 512'(1'b0));
    chk("rst_rd_cnt", 512'(afu_tlx_rd_cnt), 512'(3'd0));
    chk("rst_out_v", 512'(out_v), 512'(1'b0));
    chk("rst_unexp", 512'(unexp_data_err), 512'(1'b0));
    reset_n = 1'b1;
    cyc(2);

    // Job of 3 flits, data two cycles after the request
    p0 = n_pop; l0 = n_last;
    job(4'd3, 8'h5A);
    wait_req("t1_req", 10);
    chk("t1_cnt", 512'(last_cnt), 512'(3'b011));
    cyc(1);
    beats(3, 8'h5A, -1, 0);
    drain("t1_drain", 20);
    chk("t1_pops", 512'(n_pop - p0), 512'(3));
    chk("t1_lasts", 512'(n_last - l0), 512'(1));
    chk("t1_bad", 512'(last_bad), 512'(1'b0));
    chk("t1_tag", 512'(last_tag), 512'(8'h5A));

    // Job of 8 flits with one bad middle beat
    p0 = n_pop; b0 = n_bdi;
    job(4'd8, 8'hC3);
    wait_req("t2_req", 10);
    chk("t2_cnt", 512'(last_cnt), 512'(3'b000));
    beats(8, 8'hC3, 4, 1);
    drain("t2_drain", 20);
    chk("t2_pops", 512'(n_pop - p0), 512'(8));
    chk("t2_bdi_beats", 512'(n_bdi - b0), 512'(1));
    chk("t2_bad", 512'(last_bad), 512'(1'b1));

    // Full buffer holds back the next request until a beat is popped
    out_rdy = 1'b0; p0 = n_pop; r0 = n_req;
    job(4'd8, 8'h11);
    wait_req("t3_req1", 10);
    beats(8, 8'h11, -1, 0);
    job(4'd1, 8'h22);
    cyc(6);
    chk("t3_withheld", 512'(n_req - r0), 512'(1));
    chk("t3_full_v", 512'(out_v), 512'(1'b1));
    out_rdy = 1'b1;
    cyc(1);
    out_rdy = 1'b0;
    wait_req("t3_req2", 5);
    chk("t3_cnt", 512'(last_cnt), 512'(3'b001));
    beats(1, 8'h22, -1, 0);
    out_rdy = 1'b1;
    drain("t3_drain", 30);
    chk("t3_pops", 512'(n_pop - p0), 512'(9));
    chk("t3_tag", 512'(last_tag), 512'(8'h22));

    // Illegal flit counts are rejected
    e0 = n_err; r0 = n_req;
    job(4'd0, 8'h01);
    cyc(1);
    job(4'd9, 8'h02);
    cyc(3);
    chk("t4_errs", 512'(n_err - e0), 512'(2));
    chk("t4_no_req", 512'(n_req - r0), 512'(0));
    chk("t4_idle", 512'(job_rdy), 512'(1'b1));

    // Unexpected data while idle
    beats(1, 8'h77, -1, 0);
    cyc(1);
    chk("t5_unexp", 512'(unexp_data_err), 512'(1'b1));
    chk("t5_out_v", 512'(out_v), 512'(1'b0));
    cyc(4);
    chk("t5_sticky", 512'(unexp_data_err), 512'(1'b1));

    // Reset in the middle of a 4-flit job
    out_rdy = 1'b0;
    job(4'd4, 8'h44);
    wait_req("t6_req", 10);
    beats(2, 8'h44, -1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_out_v", 512'(out_v), 512'(1'b0));
    chk("t6_rst_job_rdy", 512'(job_rdy), 512'(1'b1));
    chk("t6_rst_rd_req", 512'(afu_tlx_rd_req), 512'(1'b0));
    chk("t6_rst_unexp", 512'(unexp_data_err), 512'(1'b0));
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    beats(2, 8'h45, -1, 0);
    cyc(1);
    chk("t6_late_unexp", 512'(unexp_data_err), 512'(1'b1));
    out_rdy = 1'b1; p0 = n_pop;
    job(4'd5, 8'h55);
    wait_req("t6_req2", 10);
    beats(5, 8'h55, 2, 1);
    drain("t6_drain2", 30);
    job(4'd6, 8'h66);
    wait_req("t6_req3", 10);
    beats(6, 8'h66, -1, 0);
    drain("t6_drain3", 30);
    chk("t6_pops", 512'(n_pop - p0), 512'(11));
    chk("t6_tag", 512'(last_tag), 512'(8'h66));
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
